// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, frame width and baud divisor helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam int UART_DATA_BITS = 8;
    function automatic int div_for(input int clk_hz, input int baud);
        return clk_hz / baud - 1;
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: registered sync FIFO with wrap-around pointers; pop and push may share a cycle
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
    // pointer advance; the extra MSB separates full from empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with input synchronizer, mid-bit sampling FSM and byte FIFO
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 rx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 framing_error,
    output logic                 overflow,
    input  logic                 clear_errors,
    output logic                 busy
);
    state_t state, state_n;
    logic rx_m, rx_s;
    logic [DIV_WIDTH-1:0] cnt, div_l;
    logic [2:0] bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic tick, push, pop, full, empty, stop_bad;
    assign tick = cnt == '0;
    assign push = state == STOP && tick && rx_s;
    assign stop_bad = state == STOP && tick && !rx_s;
    assign pop = out_valid && out_ready;
    assign out_valid = !empty;
    assign busy = state != IDLE;
    // two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // next state; a low stop bit parks in BREAK until the line returns high
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   if (tick) state_n = rx_s ? IDLE : DATA;
            DATA:    if (tick && bit_idx == 3'd7) state_n = STOP;
            STOP:    if (tick) state_n = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // bit timer and shifter; divisor is captured at the start edge so later changes wait a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            div_l <= '0;
            bit_idx <= '0;
            shift <= '0;
        end else if (state == IDLE) begin
            if (!rx_s) begin
                div_l <= divisor;
                cnt <= divisor >> 1;
            end
        end else if (state != BREAK) begin
            cnt <= tick ? div_l : cnt - DIV_WIDTH'(1);
            if (tick && state == START) bit_idx <= '0;
            if (tick && state == DATA) begin
                shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end
    // sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            framing_error <= 1'b0;
            overflow <= 1'b0;
        end else begin
            framing_error <= stop_bad | (framing_error & ~clear_errors);
            overflow <= (push & full & ~pop) | (overflow & ~clear_errors);
        end
    end
    uart_rx_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (shift),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Synchronous 8N1 UART receiver. It deserializes the serial input line into bytes and presents them on a valid/ready byte stream through a small FIFO. It is the receive-direction counterpart of the SoC UART transmit path and shares that path's divisor convention: divisor = clocks_per_bit - 1, e.g. 5 for 96 MHz / 16 Mbaud. It is used both as the SoC RX front end and as the synthesizable capture block for the uart_tx line.

Parameters:
DIV_WIDTH, 16, width of the divisor input.
FIFO_DEPTH, 4, received-byte buffer entries; power of two, minimum 2.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
divisor  input  DIV_WIDTH  clocks per bit minus 1; legal values are >= 3; latched at each start-bit detection.
rx  input  1  serial line; asynchronous; idles high.
out_valid  output  1  byte available.
out_ready  input  1  consumer accepts the byte.
out_data  output  8  received byte; LSB is the first bit on the wire.
framing_error  output  1  sticky flag; stop bit sampled low.
overflow  output  1  sticky flag; byte dropped because the FIFO was full.
clear_errors  input  1  single-cycle pulse that clears both sticky flags.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset values:
- All outputs 0.
- FIFO empty; FSM in IDLE.
- Both synchronizer flops at 1.

Input synchronization:
- rx passes through a 2-flop synchronizer; rx_s is the second-stage output.
- All decisions use rx_s only.

Bit timer:
- cnt down-counter; a "tick" occurs when cnt == 0.
- On a tick in START, DATA or STOP, cnt reloads with div_l.
- bit_idx is 3 bits.

FSM:
- IDLE: when rx_s == 0, latch div_l = divisor, set cnt = div_l >> 1 (mid-bit), go to START.
- START: on tick, if rx_s == 0, set bit_idx = 0 and go to DATA. If rx_s == 1 the edge was a glitch: return to IDLE with no flag raised.
- DATA: on tick, shift = {rx_s, shift[7:1]}. When bit_idx == 7 go to STOP; otherwise increment bit_idx.
- STOP, on tick with rx_s == 1:
  - Push shift into the FIFO and go to IDLE.
  - If the FIFO is full and there is no pop in the same cycle, drop the byte and set overflow.
- STOP, on tick with rx_s == 0:
  - Discard the byte, set framing_error, go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. This prevents a break condition from producing 0x00 bytes.

Latency:
- out_valid rises 1 cycle after the stop-bit tick when the FIFO was empty.
- The stop-bit tick lands 2 sync cycles + (div_l >> 1) + 9*(div_l+1) cycles after the rx falling edge, give or take the reload alignment.

Output stream:
- out_data = FIFO head.
- Pop happens when out_valid && out_ready.
- While out_valid is high and out_ready is low, out_valid and out_data hold stable.

FIFO:
- Registered, DEPTH entries, wrap-around pointers with an extra MSB for full/empty.
- Push and pop in the same cycle:
  - When full: both succeed, count unchanged, no overflow.
  - When empty: the push proceeds; out_valid rises the next cycle.

Sticky flags:
- A set and clear_errors in the same cycle: the set wins.
- Flags never self-clear.

Other rules:
- A divisor change mid-frame has no effect until the next start bit.
- divisor < 3 gives undefined data but must not deadlock the FSM.
- An asynchronous reset mid-frame aborts the frame: no push, FSM to IDLE.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - UART_DATA_BITS = 8;
  - the divisor-convention constant/function div_for(clk_hz, baud) = clk_hz/baud - 1.
- Sub-module uart_rx_fifo: the generic sync FIFO (width 8, depth FIFO_DEPTH, push/pop/full/empty). The receiver FSM, synchronizer and timer stay in uart_receiver.

Test Plan:
1. divisor=5, bench sends 0x55 then 0xA3 at 6-clock bit time, out_ready=1 -> two out_valid pulses with 0x55 then 0xA3; no flags; busy low between frames.
2. divisor=5, rx low for 2 clocks only, then high -> no byte, no flag, FSM back in IDLE within 5 cycles.
3. divisor=5, send 0x7E with the stop bit driven low, then release rx high after 20 bit times -> framing_error=1, no byte pushed; next byte 0x11 is received correctly; clear_errors pulse -> framing_error=0.
4. FIFO_DEPTH=4, out_ready=0, send 0x01..0x05 -> overflow=1; then out_ready=1 drains exactly 0x01,0x02,0x03,0x04 in order.
5. FIFO full, out_ready=1 held, stop-bit tick of 0x06 coincides with a pop -> 0x06 stored, overflow stays 0.
6. Assert reset during bit 4 of a frame, deassert, send 0xC4 -> only 0xC4 delivered; all outputs 0 during reset.
